// File: rtl/adder_seq_ctrl.sv
// Multi-precision add sequencer: one WIDTH-bit adder reused LSW first over WORDS cycles.
// Optional subtract mode (op_sub port) is enabled by defining ADD_SEQ_SUB_EN.

module adder_16bit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum      = full[WIDTH-1:0];
    assign cout     = full[WIDTH];
    // Signed overflow: same operand signs, different result sign.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] a,
    input  logic [WORDS*WIDTH-1:0] b,
    input  logic                   cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                   op_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   overflow,
    output logic                   busy
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic                   carry_reg;
    logic [WORDS*WIDTH-1:0] a_reg;
    logic [WORDS*WIDTH-1:0] b_reg;
    logic [WORDS*WIDTH-1:0] sum_reg;
    logic                   cout_reg;
    logic                   overflow_reg;
    logic                   out_valid_reg;
    logic                   in_ready_reg;
    logic                   busy_reg;

    logic                   sub_active;
    logic                   start_carry;
    logic                   accept;

`ifdef ADD_SEQ_SUB_EN
    logic sub_reg;
    assign sub_active  = sub_reg;
    // Subtraction is a + ~b + 1, so the external carry-in is ignored.
    assign start_carry = op_sub ? 1'b1 : cin;
`else
    assign sub_active  = 1'b0;
    assign start_carry = cin;
`endif

    logic [WIDTH-1:0] a_words [WORDS];
    logic [WIDTH-1:0] b_words [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign a_words[gi] = a_reg[gi*WIDTH +: WIDTH];
            assign b_words[gi] = b_reg[gi*WIDTH +: WIDTH] ^ {WIDTH{sub_active}};
        end
    endgenerate

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_overflow;

    adder_16bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a        (a_words[idx_reg]),
        .b        (b_words[idx_reg]),
        .cin      (carry_reg),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_overflow)
    );

    assign accept = in_valid && in_ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg        <= a;
                        b_reg        <= b;
`ifdef ADD_SEQ_SUB_EN
                        sub_reg      <= op_sub;
`endif
                        carry_reg    <= start_carry;
                        idx_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*WIDTH +: WIDTH] <= add_sum;
                    carry_reg <= add_cout;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg      <= add_cout;
                        overflow_reg  <= add_overflow;
                        idx_reg       <= '0;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;
    assign busy      = busy_reg;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (WIDTH=16, WORDS=4); subtract cases run when ADD_SEQ_SUB_EN is defined.

module tb_adder_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;
    logic        busy;
`ifdef ADD_SEQ_SUB_EN
    logic        op_sub;
`endif

    int total = 0;
    int bad   = 0;

    adder_seq_ctrl #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after the accept edge.
    task automatic start_op(input logic [63:0] ta, input logic [63:0] tb, input logic tcin,
                            input logic tsub);
`ifdef ADD_SEQ_SUB_EN
        op_sub = tsub;
`else
        if (tsub) $display("subtract request skipped in add-only build");
`endif
        a = ta;
        b = tb;
        cin = tcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 64'hDEAD_BEEF_DEAD_BEEF;
        b = 64'h0123_4567_89AB_CDEF;
        cin = 1'b1;
`ifdef ADD_SEQ_SUB_EN
        op_sub = ~tsub;
`endif
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(WORDS));
    endtask

    task automatic check_result(input string tag, input logic [63:0] es, input logic ec,
                                input logic eo);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, overflow, eo);
        $display("%s: sum=%h cout=%0b ovf=%0b", tag, sum, cout, overflow);
    endtask

    task automatic release_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        op_sub = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_sum", sum, 64'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", overflow, 1'b0);

        // 1: carry from word 0 into word 1
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        check("t1_busy", busy, 1'b1);
        check("t1_inready", in_ready, 1'b0);
        wait_done("t1");
        check_result("t1", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        release_op("t1");

        // 2: carry ripples through all words
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        wait_done("t2");
        check_result("t2", 64'h0, 1'b1, 1'b0);
        release_op("t2");

        // 3: signed overflow on top word
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done("t3");
        check_result("t3", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        release_op("t3");

        // mixed pattern with cin
        start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        wait_done("mix");
        check_result("mix", 64'h2222_2222_2222_2212, 1'b0, 1'b0);
        release_op("mix");

        // 4: back-pressure in DONE, stray in_valid ignored
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        wait_done("t4");
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            a = 64'h5555_5555_5555_5555;
            tick();
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_sum", sum, 64'h0000_0000_0001_0000);
            check("t4_hold_cout", cout, 1'b0);
            check("t4_hold_ovf", overflow, 1'b0);
            check("t4_hold_inready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        release_op("t4");
        tick();
        check("t4_no_accept", busy, 1'b0);

        // 5: reset during the second RUN cycle aborts
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_state_ready", in_ready, 1'b1);
        check("t5_valid", out_valid, 1'b0);
        check("t5_sum", sum, 64'h0);
        check("t5_busy", busy, 1'b0);
        tick();
        check("t5_no_result", out_valid, 1'b0);
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        wait_done("t5b");
        check_result("t5b", 64'h0, 1'b1, 1'b0);
        release_op("t5b");

`ifdef ADD_SEQ_SUB_EN
        // 6: subtraction
        start_op(64'h0, 64'h1, 1'b0, 1'b1);
        wait_done("t6a");
        check_result("t6a", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        release_op("t6a");
        start_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
        wait_done("t6b");
        check_result("t6b", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        release_op("t6b");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
